// File: rtl/icache_ro_pkg.sv
// Shared definitions for the read-only instruction cache: FSM encoding,
// line geometry and fetch-address field layout.
package icache_ro_pkg;

  localparam int ADDR_W         = 30;
  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFF_W          = 2;
  localparam int MEM_ADDR_W     = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REFILL = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[WORD_W*off +: WORD_W];
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: one combinational read
// port, one synchronous write port, valid bits cleared by async reset.
module icache_line_array
  import icache_ro_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] data [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = data[rd_index];

endmodule

// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache with zero-latency hits and a
// single-line refill FSM. Define ICACHE_PERF_EN to add hit/miss counters.
module icache_ro
  import icache_ro_pkg::*;
#(
  parameter int LINES   = 8,
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  proc_read,
  input  logic                  proc_write,
  input  logic [ADDR_W-1:0]     proc_addr,
  input  logic [WORD_W-1:0]     proc_wdata,
  output logic [WORD_W-1:0]     proc_rdata,
  output logic                  proc_stall,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]     mem_wdata,
  input  logic [LINE_W-1:0]     mem_rdata,
  input  logic                  mem_ready
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]           perf_hit,
  output logic [31:0]           perf_miss
`endif
);

  state_t             state;
  logic [TAG_W-1:0]   addr_tag;
  logic [INDEX_W-1:0] addr_index;
  logic [OFF_W-1:0]   addr_off;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               hit;
  logic               idle;
  logic               miss;
  logic               wr_en;
  logic               unused_inputs;

  assign addr_tag   = proc_addr[ADDR_W-1 -: TAG_W];
  assign addr_index = proc_addr[OFF_W +: INDEX_W];
  assign addr_off   = proc_addr[OFF_W-1:0];

  icache_line_array #(
    .LINES   (LINES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_index (addr_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_index (mem_addr[INDEX_W-1:0]),
    .wr_tag   (mem_addr[MEM_ADDR_W-1 -: TAG_W]),
    .wr_line  (mem_rdata)
  );

  assign hit        = proc_read & rd_valid & (rd_tag == addr_tag);
  assign idle       = (state == S_IDLE);
  assign miss       = idle & proc_read & ~hit;
  assign proc_stall = ~idle | miss;
  assign proc_rdata = hit ? line_word(rd_line, addr_off) : '0;
  // Only a REFILL-state mem_ready writes the array; stray pulses are dropped.
  assign wr_en      = (state == S_REFILL) & mem_ready;

  assign mem_write     = 1'b0;
  assign mem_wdata     = '0;
  assign unused_inputs = proc_write ^ (^proc_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      mem_read <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            mem_addr <= proc_addr[ADDR_W-1:OFF_W];
            mem_read <= 1'b1;
            state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            mem_read <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else begin
      if (idle && hit) perf_hit  <= perf_hit + 32'd1;
      if (miss)        perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ro.sv
// Self-checking bench for icache_ro: directed scenarios with literal
// expectations plus randomized traffic against a cache/memory model.
module tb_icache_ro;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         proc_read = 1'b0;
  logic         proc_write = 1'b0;
  logic [29:0]  proc_addr = '0;
  logic [31:0]  proc_wdata = '0;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;
`endif

  icache_ro dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: cache contents, refill progress (0 idle, 1 awaiting line, 2 settle cycle).
  bit           mvalid [8];
  logic [24:0]  mtag   [8];
  logic [127:0] mline  [8];
  int           phase = 0;
  int           lat_left = 0;
  int           lat_max = 2;
  bit           spur_en = 1'b0;
  logic [27:0]  req = '0;
  logic [31:0]  mhit = '0;
  logic [31:0]  mmiss = '0;

  logic         s_stall;
  logic         s_mem_read;
  logic [27:0]  s_mem_addr;
  logic [31:0]  s_rdata;

  function automatic logic [127:0] line_of(input logic [27:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = {4'hD, 4'(k), a[23:0]};
    return l;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    phase = 0;
    lat_left = 0;
    mhit = '0;
    mmiss = '0;
  endtask

  task automatic cycle(input logic pr, input logic [29:0] pa, input logic force_mr);
    logic        mr;
    logic [2:0]  idx;
    logic [24:0] tg;
    bit          hit;
    bit          exp_stall;
    mr = 1'b0;
    @(negedge clk);
    if (phase == 1) begin
      if (lat_left == 0) mr = 1'b1;
      else lat_left--;
    end else begin
      mr = force_mr | (spur_en && ($urandom_range(0, 7) == 0));
    end
    proc_read  = pr;
    proc_addr  = pa;
    proc_write = 1'($urandom_range(0, 1));
    proc_wdata = $urandom;
    mem_ready  = mr;
    mem_rdata  = (mr && phase == 1) ? line_of(req) : {$urandom, $urandom, $urandom, $urandom};
    #1;
    s_stall    = proc_stall;
    s_mem_read = mem_read;
    s_mem_addr = mem_addr;
    s_rdata    = proc_rdata;

    idx = pa[4:2];
    tg  = pa[29:5];
    hit = (phase == 0) && pr && mvalid[idx] && (mtag[idx] == tg);
    exp_stall = (phase != 0) || (pr && !hit);
    check("stall", 128'(proc_stall), 128'(exp_stall));
    check("mem_read", 128'(mem_read), 128'(phase == 1));
    if (phase == 1) check("mem_addr", 128'(mem_addr), 128'(req));
    if (hit) check("rdata", 128'(proc_rdata), 128'(mline[idx][32*pa[1:0] +: 32]));
    check("mem_write_tie", {mem_write, mem_wdata}, 128'd0);
`ifdef ICACHE_PERF_EN
    check("perf_hit", 128'(perf_hit), 128'(mhit));
    check("perf_miss", 128'(perf_miss), 128'(mmiss));
`endif

    case (phase)
      0: begin
        if (pr && !hit) begin
          phase    = 1;
          req      = pa[29:2];
          lat_left = $urandom_range(0, lat_max);
          mmiss    = mmiss + 32'd1;
        end else if (hit) begin
          mhit = mhit + 32'd1;
        end
      end
      1: begin
        if (mr) begin
          mvalid[req[2:0]] = 1'b1;
          mtag[req[2:0]]   = req[27:3];
          mline[req[2:0]]  = mem_rdata;
          phase = 2;
        end
      end
      default: phase = 0;
    endcase
  endtask

  task automatic run_until_idle(input logic pr, input logic [29:0] pa);
    int n;
    n = 0;
    while (phase != 0 && n < 20) begin
      cycle(pr, pa, 1'b0);
      n++;
    end
    if (phase != 0) begin
      tests++;
      fails++;
      $display("FAIL refill_timeout: got phase %0d expected 0", phase);
      phase = 0;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #2;
    proc_read = 1'b0;
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("rst_mem_read", 128'(mem_read), 128'd0);
    check("rst_stall", 128'(proc_stall), 128'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, 30'h0, 1'b0);
    check("reset_stall", 128'(s_stall), 128'd0);
    check("reset_mem_read", 128'(s_mem_read), 128'd0);
    check("reset_mem_addr", 128'(s_mem_addr), 128'd0);
    check("reset_rdata", 128'(s_rdata), 128'd0);

    // Cold miss on word address 0x4 (index 1, tag 0, offset 0)
    cycle(1'b1, 30'h4, 1'b0);
    check("cold_stall", 128'(s_stall), 128'd1);
    cycle(1'b1, 30'h4, 1'b0);
    check("cold_mem_read", 128'(s_mem_read), 128'd1);
    check("cold_mem_addr", 128'(s_mem_addr), 128'h1);
    run_until_idle(1'b1, 30'h4);
    cycle(1'b1, 30'h4, 1'b0);
    check("hit_w0_stall", 128'(s_stall), 128'd0);
    check("hit_w0_rdata", 128'(s_rdata), 128'h D000_0001);
    cycle(1'b1, 30'h5, 1'b0);
    cycle(1'b1, 30'h6, 1'b0);
    cycle(1'b1, 30'h7, 1'b0);
    check("hit_w3_rdata", 128'(s_rdata), 128'h D300_0001);
    check("hit_w3_mem_read", 128'(s_mem_read), 128'd0);

    // Conflict on index 0 between tags 1 and 0
    cycle(1'b1, 30'h20, 1'b0);
    check("conf_stall", 128'(s_stall), 128'd1);
    cycle(1'b1, 30'h20, 1'b0);
    check("conf_mem_addr", 128'(s_mem_addr), 128'h8);
    run_until_idle(1'b1, 30'h20);
    cycle(1'b1, 30'h20, 1'b0);
    check("conf_rdata", 128'(s_rdata), 128'h D000_0008);
    cycle(1'b1, 30'h0, 1'b0);
    check("conf_remiss", 128'(s_stall), 128'd1);
    run_until_idle(1'b1, 30'h0);

    // Address changes while the refill for 0x40 is outstanding
    lat_max = 0;
    cycle(1'b1, 30'h40, 1'b0);
    lat_left = 3;
    cycle(1'b1, 30'h4, 1'b0);
    check("swap_mem_addr", 128'(s_mem_addr), 128'h10);
    cycle(1'b1, 30'h64, 1'b0);
    run_until_idle(1'b1, 30'h64);
    cycle(1'b1, 30'h64, 1'b0);
    check("swap_new_miss", 128'(s_stall), 128'd1);
    cycle(1'b1, 30'h64, 1'b0);
    check("swap_new_addr", 128'(s_mem_addr), 128'h19);
    run_until_idle(1'b1, 30'h64);
    lat_max = 2;

    // Reset while a refill is outstanding, then a late mem_ready
    cycle(1'b1, 30'h84, 1'b0);
    lat_left = 5;
    cycle(1'b1, 30'h84, 1'b0);
    async_reset();
    cycle(1'b0, 30'h84, 1'b1);
    check("late_ready_mem_read", 128'(s_mem_read), 128'd0);
    cycle(1'b1, 30'h4, 1'b0);
    check("post_rst_miss", 128'(s_stall), 128'd1);
    run_until_idle(1'b1, 30'h4);

    // Randomized traffic with stray mem_ready pulses
    spur_en = 1'b1;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [29:0] pa;
      pa = {25'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      cycle(1'($urandom_range(0, 3) != 0), pa, 1'b0);
    end
    spur_en = 1'b0;

    async_reset();
    cycle(1'b1, 30'h4, 1'b0);
    run_until_idle(1'b1, 30'h4);
    cycle(1'b1, 30'h4, 1'b0);
    cycle(1'b1, 30'h5, 1'b0);
    cycle(1'b1, 30'h6, 1'b0);
    cycle(1'b0, 30'h7, 1'b0);
    cycle(1'b0, 30'h7, 1'b0);
`ifdef ICACHE_PERF_EN
    check("perf_hit_lit", 128'(perf_hit), 128'd3);
    check("perf_miss_lit", 128'(perf_miss), 128'd1);
`endif
    check("final_idle_stall", 128'(s_stall), 128'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
